mul_seq_hilo: RTL and testbench
===============================

Name: mul_seq_hilo

Overview:
- Iterative shift-and-add multiplier for the EX stage, serving MULT and MULTU.
- Each iteration issues one WIDTH-bit add with carry-in, the same operation as the team's ADC32 adder, and consumes its sum and carry-out.
- Produces the 2*WIDTH-bit product into HI/LO registers and raises busy so the hazard unit can stall MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- sign  input  1  1 = MULT (two's complement), 0 = MULTU.
- A  input  WIDTH  multiplicand, sampled with start.
- B  input  WIDTH  multiplier, sampled with start.
- busy  output  1  high from the cycle after accepted start until the result is written.
- done  output  1  one-cycle pulse, coincident with HI/LO update.
- hi  output  WIDTH  upper product half; held until the next result.
- lo  output  WIDTH  lower product half; held until the next result.

Behaviour:
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, iteration count=0, internal accumulator=0.
- States are IDLE, CALC and SIGN.
- IDLE:
  - On start=1, latch the operand magnitudes, capture neg = sign & (A[W-1] ^ B[W-1]), clear the accumulator and count, go to CALC, set busy=1.
  - Magnitude: if sign=1 and the MSB is 1, the operand is ~x + 1, formed as an add with C0=1; otherwise x.
  - start=0: remain in IDLE; done=0.
- CALC, one iteration per clock:
  - If multiplier LSB=1: {c, acc_hi} = acc_hi + mcand with C0=0; otherwise c=0 and acc_hi is unchanged.
  - Then shift {c, acc_hi, acc_lo/multiplier} right by 1 (shared-register form); count++.
  - After the WIDTH-th iteration, go to SIGN.
- SIGN:
  - Write {hi,lo} = neg ? (~P + 1) : P over 2*WIDTH bits. The low half uses C0=1; the carry from the low half feeds the high half.
  - Pulse done=1, set busy=0, return to IDLE.
- Latency: start sampled at edge 0; hi/lo/done update at edge WIDTH+1 (edge 33 for WIDTH=32). done is high for exactly one cycle.
- A new start may be accepted in the same cycle done is high, because the state is already IDLE.
- start while busy=1: ignored. No queuing; operands are not re-latched.
- Operand changes after the start edge: no effect.
- Magnitude edge case: with sign=1, the magnitude of 0x80000000 is 0x80000000 as an unsigned value. The product must still be correct, e.g. (-2^31)*(-2^31) = 2^62.
- rst asserted mid-operation: the operation is aborted. All state and outputs return to reset values on that edge; no done pulse.
- rst has priority over start in the same cycle.
- All arithmetic is modulo 2^(2*WIDTH). No overflow flag.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: in IDLE, if start=1 and A==0 or B==0, go directly to SIGN. The result is 0 (neg is forced to 0), and done pulses at edge 1 with busy high for one cycle.
- Not defined: zero operands take the full WIDTH+1 latency and produce a 0 result.

Test Plan:
- Unsigned wrap: sign=0, A=0xFFFFFFFF, B=2 -> at edge 33, hi=0x00000001, lo=0xFFFFFFFE, done pulse for one cycle, busy low after.
- Signed negative: sign=1, A=0xFFFFFFFF (-1), B=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Small and edge operands:
  - sign=0, A=100, B=13 -> hi=0, lo=0x00000514.
  - sign=1, A=B=0x80000000 -> hi=0x40000000, lo=0.
  - sign=0, A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- start pulsed again at edge 10 with A=5, B=5 during an active op -> ignored; the first result is unchanged; the following start is accepted on the done cycle, producing lo=25 33 edges later.
- rst at edge 15 of an op -> busy=0, hi=lo=0, no done.
- MUL_ZERO_SKIP_EN: A=0, B=7 -> done at edge 1 with hi=lo=0. Without the macro, done at edge 33.

Source files
------------

// File: rtl/mul_seq_hilo.sv
// Iterative shift-and-add MULT/MULTU unit writing a 2*WIDTH-bit product into HI/LO.
// Optional MUL_ZERO_SKIP_EN: a zero operand bypasses the iterations and finishes in one cycle.
module mul_seq_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_e;

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // Same operation as ADC32: {carry, sum} = a + b + cin.
  function automatic logic [WIDTH:0] adc(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    step;
  logic [WIDTH:0]    lo_fix;
  logic [WIDTH-1:0]  hi_fix;

  always_comb begin
    mag_a = (sign && A[WIDTH-1]) ? WIDTH'(adc(~A, '0, 1'b1)) : A;
    mag_b = (sign && B[WIDTH-1]) ? WIDTH'(adc(~B, '0, 1'b1)) : B;
    // Adding zero when the multiplier LSB is clear leaves acc_hi intact with c=0.
    step   = adc(acc_hi_q, acc_lo_q[0] ? mcand_q : '0, 1'b0);
    lo_fix = adc(neg_q ? ~acc_lo_q : acc_lo_q, '0, neg_q);
    hi_fix = WIDTH'(adc(neg_q ? ~acc_hi_q : acc_hi_q, '0, lo_fix[WIDTH]));
  end

  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = mag_a;
          acc_lo_d = mag_b;
          acc_hi_d = '0;
          neg_d    = sign & (A[WIDTH-1] ^ B[WIDTH-1]);
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = S_CALC;
`ifdef MUL_ZERO_SKIP_EN
          if (A == '0 || B == '0) begin
            acc_lo_d = '0;
            neg_d    = 1'b0;
            state_d  = S_SIGN;
          end
`endif
        end
      end
      S_CALC: begin
        acc_hi_d = {step[WIDTH], step[WIDTH-1:1]};
        acc_lo_d = {step[0], acc_lo_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == LAST) state_d = S_SIGN;
      end
      S_SIGN: begin
        lo_d    = lo_fix[WIDTH-1:0];
        hi_d    = hi_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_seq_hilo.sv
// Self-checking bench for mul_seq_hilo: expected products queued at start, compared at done.
module tb_mul_seq_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [63:0] exp_q[$];

  mul_seq_hilo #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sign (sign),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = s ? {{32{a[31]}}, a} : {32'b0, a};
    xb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  function automatic int unsigned exp_lat(input logic [31:0] a, input logic [31:0] b);
    int unsigned l;
    l = 33;
`ifdef MUL_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) l = 1;
`endif
    return l;
  endfunction

  // Wait for done after the start edge; compare latency and the popped expected product.
  task automatic wait_result(input string name, input int unsigned lat);
    int unsigned cyc;
    logic        seen;
    logic [63:0] e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 45) begin
      tick();
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    n_chk++;
    if (!seen || cyc != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", name, cyc, seen, lat);
    end
    n_chk++;
    if (hi !== e[63:32]) begin
      n_fail++;
      $display("FAIL %s hi: got %h expected %h", name, hi, e[63:32]);
    end
    n_chk++;
    if (lo !== e[31:0]) begin
      n_fail++;
      $display("FAIL %s lo: got %h expected %h", name, lo, e[31:0]);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] e, input string name);
    A = a; B = b; sign = s; start = 1'b1;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; sign = 1'($urandom_range(0, 1));
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    wait_result(name, exp_lat(a, b));
    tick();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sign = 1'b0; A = '0; B = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    n_chk++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset hilo: got %h_%h expected 0_0", hi, lo);
    end
  endtask

  task automatic test_products();
    run_op(32'hFFFFFFFF, 32'd2,       1'b0, 64'h00000001_FFFFFFFE, "unsigned_wrap");
    run_op(32'hFFFFFFFF, 32'd2,       1'b1, 64'hFFFFFFFF_FFFFFFFE, "signed_neg");
    run_op(32'd100,      32'd13,      1'b0, 64'h00000000_00000514, "small");
    run_op(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "min_sq");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "max_sq");
    run_op(32'h80000000, 32'd3,       1'b1, 64'hFFFFFFFE_80000000, "min_x3");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; s = 1'(i % 2);
      run_op(a, b, s, model(a, b, s), "random");
    end
  endtask

  task automatic test_zero();
    run_op(32'd0,        32'd7, 1'b0, 64'd0, "zero_a");
    run_op(32'hFFFFFFF9, 32'd0, 1'b1, 64'd0, "zero_b_signed");
  endtask

  task automatic test_back_to_back();
    int unsigned cyc;
    A = 32'hFFFFFFFF; B = 32'd3; sign = 1'b0; start = 1'b1;
    exp_q.push_back(64'h00000002_FFFFFFFD);
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 9) begin
      tick();
      cyc++;
    end
    A = 32'd5; B = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    // 10 edges consumed; the first result still lands 33 edges after its start.
    wait_result("ignored_start", 23);
    A = 32'd5; B = 32'd5; sign = 1'b0; start = 1'b1;
    exp_q.push_back(64'd25);
    tick();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_on_done busy: got %b expected 1", busy);
    end
    wait_result("start_on_done", 33);
  endtask

  task automatic test_reset_mid();
    int unsigned ndone;
    A = 32'd12345; B = 32'd678; sign = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b hilo=%h_%h expected 0 0 0_0", busy, done, hi, lo);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    n_chk++;
    if (ndone != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: got %0d done pulses busy=%b expected 0 0", ndone, busy);
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_random();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
